// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared ExcCode constants, handler address and stage record type
package exc_pkg;

  // Cause.ExcCode values used by the stage checkers
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Default exception/interrupt entry PC
  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;

  // Exception state carried next to each pipeline register
  typedef struct packed {
    logic        v;      // stage holds a real instruction
    logic [31:0] pc;     // instruction PC
    logic        bd;     // instruction sits in a branch delay slot
    logic        xv;     // an exception has been recorded for it
    logic [4:0]  xcode;  // ExcCode of the oldest recorded exception
  } excRecT;

  localparam excRecT REC_BUBBLE = '0;

endpackage

// File: rtl/exc_stage_reg.sv
// rtl/exc_stage_reg.sv - one pipeline stage's exception record with merge, hold and bubble
module exc_stage_reg
  import exc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  excRecT     recIn,
  input  logic       excGet,
  input  logic [4:0] excCode,
  input  logic       mergeEn,
  input  logic       hold,
  input  logic       bubble,
  output excRecT     recOut
);

  excRecT rec;

  // Fold this stage's checker result in unless an older exception is already recorded
  always_comb begin
    recOut = rec;
    if (mergeEn && rec.v && !rec.xv && excGet) begin
      recOut.xv    = 1'b1;
      recOut.xcode = excCode;
    end
  end

  // Bubble beats hold; a held record keeps its merged exception so it is not lost
  always_ff @(posedge clk) begin
    if (reset) begin
      rec <= REC_BUBBLE;
    end else if (bubble) begin
      rec <= REC_BUBBLE;
    end else if (hold) begin
      rec <= recOut;
    end else begin
      rec <= recIn;
    end
  end

endmodule

// File: rtl/exc_pipe_ctrl.sv
// rtl/exc_pipe_ctrl.sv - exception/interrupt/eret sequencer for the five-stage pipeline
module exc_pipe_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] f_pc,
  input  logic        f_bd,
  input  logic        f_exc_get,
  input  logic [4:0]  f_exc_code,
  input  logic        d_exc_get,
  input  logic [4:0]  d_exc_code,
  input  logic        e_exc_get,
  input  logic [4:0]  e_exc_code,
  input  logic        m_exc_get,
  input  logic [4:0]  m_exc_code,
  input  logic        m_eret,
  input  logic        int_req,
  input  logic [31:0] epc_in,
  output logic        exc_take,
  output logic [4:0]  exc_code,
  output logic        exc_bd,
  output logic [31:0] exc_epc,
  output logic        eret_take,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic        m_bubble
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  logic [0:0] state;
  logic [0:0] stateNext;
  logic       inRun;
  logic       commitEn;
  logic       takeNow;
  logic       eretNow;
  logic       flushNow;
  excRecT     fRec;
  excRecT     dRec;
  excRecT     eRec;
  excRecT     mRec;

  assign inRun    = (state == ST_RUN);
  assign commitEn = inRun && !reset;

  // F record is built straight from the fetch inputs; checkers are ignored while squashing
  always_comb begin
    fRec    = REC_BUBBLE;
    fRec.v  = 1'b1;
    fRec.pc = f_pc;
    fRec.bd = f_bd;
    if (inRun && f_exc_get) begin
      fRec.xv    = 1'b1;
      fRec.xcode = f_exc_code;
    end
  end

  exc_stage_reg uStageD (
    .clk     (clk),
    .reset   (reset),
    .recIn   (fRec),
    .excGet  (d_exc_get),
    .excCode (d_exc_code),
    .mergeEn (inRun),
    .hold    (stall),
    .bubble  (flushNow),
    .recOut  (dRec)
  );

  exc_stage_reg uStageE (
    .clk     (clk),
    .reset   (reset),
    .recIn   (dRec),
    .excGet  (e_exc_get),
    .excCode (e_exc_code),
    .mergeEn (inRun),
    .hold    (1'b0),
    .bubble  (flushNow | stall),
    .recOut  (eRec)
  );

  exc_stage_reg uStageM (
    .clk     (clk),
    .reset   (reset),
    .recIn   (eRec),
    .excGet  (m_exc_get),
    .excCode (m_exc_code),
    .mergeEn (inRun),
    .hold    (1'b0),
    .bubble  (flushNow),
    .recOut  (mRec)
  );

  // Commit decision at M: interrupt, then recorded exception, then eret
  always_comb begin
    takeNow     = 1'b0;
    eretNow     = 1'b0;
    exc_code    = 5'd0;
    exc_bd      = 1'b0;
    exc_epc     = 32'd0;
    pc_target   = 32'd0;
    if (commitEn && mRec.v) begin
      if (int_req) begin
        takeNow  = 1'b1;
        exc_code = EXC_INT;
      end else if (mRec.xv) begin
        takeNow  = 1'b1;
        exc_code = mRec.xcode;
      end else if (m_eret) begin
        eretNow  = 1'b1;
      end
    end
    if (takeNow) begin
      exc_bd    = mRec.bd;
      exc_epc   = mRec.bd ? (mRec.pc - 32'd4) : mRec.pc;
      pc_target = HANDLER_ADDR;
    end else if (eretNow) begin
      pc_target = epc_in;
    end
  end

  assign flushNow    = takeNow | eretNow;
  assign exc_take    = takeNow;
  assign eret_take   = eretNow;
  assign pc_redirect = flushNow;
  assign flush       = flushNow;
  assign m_bubble    = reset | ~mRec.v;

  // Any redirect spends one cycle in SQUASH, which always falls back to RUN
  always_comb begin
    stateNext = flushNow ? ST_SQUASH : ST_RUN;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= stateNext;
    end
  end

endmodule

// File: tb/tb_exc_pipe_ctrl.sv
// tb/tb_exc_pipe_ctrl.sv - self-checking bench for exc_pipe_ctrl
module tb_exc_pipe_ctrl;
  import exc_pkg::*;

  localparam logic [31:0] HANDLER = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] f_pc;
  logic        f_bd;
  logic        f_exc_get, d_exc_get, e_exc_get, m_exc_get;
  logic [4:0]  f_exc_code, d_exc_code, e_exc_code, m_exc_code;
  logic        m_eret;
  logic        int_req;
  logic [31:0] epc_in;
  logic        exc_take;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic        eret_take;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        flush;
  logic        m_bubble;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        live;
    logic [31:0] pc;
    logic        bd;
    logic        hasExc;
    logic [4:0]  code;
  } tokT;

  logic [4:0] codeTbl [4] = '{EXC_ADEL, EXC_ADES, EXC_RI, EXC_OV};

  exc_pipe_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .f_pc(f_pc), .f_bd(f_bd),
    .f_exc_get(f_exc_get), .f_exc_code(f_exc_code),
    .d_exc_get(d_exc_get), .d_exc_code(d_exc_code),
    .e_exc_get(e_exc_get), .e_exc_code(e_exc_code),
    .m_exc_get(m_exc_get), .m_exc_code(m_exc_code),
    .m_eret(m_eret), .int_req(int_req), .epc_in(epc_in),
    .exc_take(exc_take), .exc_code(exc_code), .exc_bd(exc_bd), .exc_epc(exc_epc),
    .eret_take(eret_take), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .flush(flush), .m_bubble(m_bubble)
  );

  always #5 clk = ~clk;

  task automatic idleInputs();
    stall = 0; f_pc = 32'h0; f_bd = 0;
    f_exc_get = 0; d_exc_get = 0; e_exc_get = 0; m_exc_get = 0;
    f_exc_code = 0; d_exc_code = 0; e_exc_code = 0; m_exc_code = 0;
    m_eret = 0; int_req = 0; epc_in = 32'h0;
  endtask

  // Leaves the caller just after a negedge with reset released and empty records
  task automatic doReset();
    @(negedge clk);
    idleInputs();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; int_req = 1; m_eret = 1; m_exc_get = 1; m_exc_code = EXC_OV; epc_in = 32'h1234;
    #1;
    checks++;
    if ({exc_take, exc_code, exc_bd, exc_epc, eret_take, pc_redirect, pc_target, flush, m_bubble} !==
        {1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_during take=%0b code=%0d epc=%h eret=%0b redir=%0b tgt=%h flush=%0b mbub=%0b want all 0 and mbub=1",
               exc_take, exc_code, exc_epc, eret_take, pc_redirect, pc_target, flush, m_bubble);
    end
    @(negedge clk);
    reset = 0; m_eret = 0; m_exc_get = 0;
    #1;
    checks++;
    if ({exc_take, flush, m_bubble} !== 3'b001) begin
      errors++;
      $display("FAIL reset_after take=%0b flush=%0b mbub=%0b want 0 0 1", exc_take, flush, m_bubble);
    end
  endtask

  task automatic test_f_adel();
    doReset();
    f_pc = 32'h3004; f_exc_get = 1; f_exc_code = EXC_ADEL;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (exc_take !== 1'b0) begin
        errors++;
        $display("FAIL adel_early cycle %0d take=%0b want 0", c, exc_take);
      end
      @(negedge clk);
      f_exc_get = 0; f_pc = f_pc + 32'd4;
    end
    #1;
    checks++;
    if ({exc_take, exc_code, exc_bd, exc_epc, pc_redirect, pc_target, flush, eret_take} !==
        {1'b1, EXC_ADEL, 1'b0, 32'h3004, 1'b1, HANDLER, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL adel_commit take=%0b code=%0d bd=%0b epc=%h redir=%0b tgt=%h flush=%0b eret=%0b want 1 4 0 3004 1 4180 1 0",
               exc_take, exc_code, exc_bd, exc_epc, pc_redirect, pc_target, flush, eret_take);
    end
    // SQUASH cycle: handler fetch sits in F; its checker fire must be ignored
    @(negedge clk);
    f_pc = HANDLER; f_exc_get = 1; f_exc_code = EXC_RI; int_req = 1;
    #1;
    checks++;
    if ({exc_take, pc_redirect, flush} !== 3'b000) begin
      errors++;
      $display("FAIL adel_squash take=%0b redir=%0b flush=%0b want 0 0 0", exc_take, pc_redirect, flush);
    end
    @(negedge clk);
    f_exc_get = 0; int_req = 0; f_pc = HANDLER + 32'd4;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({exc_take, m_bubble} !== 2'b00) begin
      errors++;
      $display("FAIL adel_handler_in_m take=%0b mbub=%0b want 0 0", exc_take, m_bubble);
    end
  endtask

  task automatic test_delay_slot();
    doReset();
    f_pc = 32'h3010; f_bd = 1;
    @(negedge clk);
    f_pc = 32'h3014; f_bd = 0;
    @(negedge clk);
    e_exc_get = 1; e_exc_code = EXC_OV;
    @(negedge clk);
    e_exc_get = 0;
    #1;
    checks++;
    if ({exc_take, exc_code, exc_bd, exc_epc} !== {1'b1, EXC_OV, 1'b1, 32'h300C}) begin
      errors++;
      $display("FAIL bd_ov take=%0b code=%0d bd=%0b epc=%h want 1 12 1 300c", exc_take, exc_code, exc_bd, exc_epc);
    end
  endtask

  task automatic test_oldest_wins();
    doReset();
    f_pc = 32'h3050; f_exc_get = 1; f_exc_code = EXC_ADEL;
    @(negedge clk);
    f_exc_get = 0; f_pc = 32'h3054; d_exc_get = 1; d_exc_code = EXC_RI;
    @(negedge clk);
    d_exc_get = 0; e_exc_get = 1; e_exc_code = EXC_OV;
    @(negedge clk);
    e_exc_get = 0; m_exc_get = 1; m_exc_code = EXC_ADES;
    #1;
    checks++;
    if ({exc_take, exc_code, exc_epc} !== {1'b1, EXC_ADEL, 32'h3050}) begin
      errors++;
      $display("FAIL oldest take=%0b code=%0d epc=%h want 1 4 3050", exc_take, exc_code, exc_epc);
    end
  endtask

  task automatic test_int_bubble();
    doReset();
    f_pc = 32'h3020; int_req = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({exc_take, m_bubble} !== 2'b01) begin
        errors++;
        $display("FAIL int_bubble cycle %0d take=%0b mbub=%0b want 0 1", c, exc_take, m_bubble);
      end
      @(negedge clk);
      f_pc = 32'h3100;
    end
    #1;
    checks++;
    if ({exc_take, exc_code, exc_bd, exc_epc, pc_target} !== {1'b1, EXC_INT, 1'b0, 32'h3020, HANDLER}) begin
      errors++;
      $display("FAIL int_take take=%0b code=%0d bd=%0b epc=%h tgt=%h want 1 0 0 3020 4180",
               exc_take, exc_code, exc_bd, exc_epc, pc_target);
    end
  endtask

  task automatic test_eret();
    doReset();
    f_pc = 32'h3060;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    m_eret = 1; epc_in = 32'h3040;
    #1;
    checks++;
    if ({eret_take, pc_redirect, pc_target, flush, exc_take} !== {1'b1, 1'b1, 32'h3040, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL eret eret=%0b redir=%0b tgt=%h flush=%0b take=%0b want 1 1 3040 1 0",
               eret_take, pc_redirect, pc_target, flush, exc_take);
    end
    @(negedge clk);
    int_req = 1;
    #1;
    checks++;
    if ({exc_take, eret_take, pc_redirect, flush} !== 4'b0000) begin
      errors++;
      $display("FAIL eret_squash take=%0b eret=%0b redir=%0b flush=%0b want 0 0 0 0",
               exc_take, eret_take, pc_redirect, flush);
    end
  endtask

  task automatic test_stall_reset();
    doReset();
    f_pc = 32'h3070;
    @(negedge clk);
    f_pc = 32'h3074; d_exc_get = 1; d_exc_code = EXC_RI; stall = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (exc_take !== 1'b0) begin
        errors++;
        $display("FAIL stall_early cycle %0d take=%0b want 0", c, exc_take);
      end
      @(negedge clk);
      d_exc_get = 0;
      if (c == 1) stall = 0;
    end
    #1;
    checks++;
    if ({exc_take, exc_code, exc_epc} !== {1'b1, EXC_RI, 32'h3070}) begin
      errors++;
      $display("FAIL stall_commit take=%0b code=%0d epc=%h want 1 10 3070", exc_take, exc_code, exc_epc);
    end
    @(negedge clk);
    @(negedge clk);
    f_pc = 32'h3080; f_exc_get = 1; f_exc_code = EXC_ADEL;
    @(negedge clk);
    f_exc_get = 0; reset = 1;
    #1;
    checks++;
    if ({exc_take, eret_take, pc_redirect, pc_target, flush, m_bubble} !== {4'b0000, 32'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midreset take=%0b eret=%0b redir=%0b tgt=%h flush=%0b mbub=%0b want 0 0 0 0 0 1",
               exc_take, eret_take, pc_redirect, pc_target, flush, m_bubble);
    end
    @(negedge clk);
    reset = 0; int_req = 1;
    #1;
    checks++;
    if ({exc_take, flush, m_bubble} !== 3'b001) begin
      errors++;
      $display("FAIL postreset take=%0b flush=%0b mbub=%0b want 0 0 1", exc_take, flush, m_bubble);
    end
    int_req = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (exc_take !== 1'b0) begin
        errors++;
        $display("FAIL postreset_cleared cycle %0d take=%0b want 0", c, exc_take);
      end
    end
  endtask

  task automatic test_random();
    tokT         pipe [3];
    tokT         nt;
    bit          sq;
    logic        take, eretT, bdx, red;
    logic [4:0]  code;
    logic [31:0] epc, tgt;
    logic [74:0] expV, gotV;
    doReset();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    sq = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      stall      = ($urandom_range(0, 3) == 0);
      f_pc       = $urandom() & 32'hFFFF_FFFC;
      f_bd       = ($urandom_range(0, 3) == 0);
      f_exc_get  = ($urandom_range(0, 9) == 0);
      d_exc_get  = ($urandom_range(0, 9) == 0);
      e_exc_get  = ($urandom_range(0, 9) == 0);
      m_exc_get  = ($urandom_range(0, 9) == 0);
      f_exc_code = codeTbl[$urandom_range(0, 3)];
      d_exc_code = codeTbl[$urandom_range(0, 3)];
      e_exc_code = codeTbl[$urandom_range(0, 3)];
      m_exc_code = codeTbl[$urandom_range(0, 3)];
      m_eret     = ($urandom_range(0, 5) == 0);
      int_req    = ($urandom_range(0, 15) == 0);
      epc_in     = $urandom() & 32'hFFFF_FFFC;
      #1;
      // each instruction keeps only the first exception any stage reports for it
      if (!sq) begin
        if (pipe[0].live && !pipe[0].hasExc && d_exc_get) begin pipe[0].hasExc = 1; pipe[0].code = d_exc_code; end
        if (pipe[1].live && !pipe[1].hasExc && e_exc_get) begin pipe[1].hasExc = 1; pipe[1].code = e_exc_code; end
        if (pipe[2].live && !pipe[2].hasExc && m_exc_get) begin pipe[2].hasExc = 1; pipe[2].code = m_exc_code; end
      end
      take = 0; eretT = 0; bdx = 0; code = 0; epc = 0; tgt = 0;
      if (!sq && pipe[2].live) begin
        if (int_req) begin
          take = 1; code = EXC_INT;
        end else if (pipe[2].hasExc) begin
          take = 1; code = pipe[2].code;
        end else if (m_eret) begin
          eretT = 1; tgt = epc_in;
        end
        if (take) begin
          bdx = pipe[2].bd;
          epc = pipe[2].bd ? pipe[2].pc - 32'd4 : pipe[2].pc;
          tgt = HANDLER;
        end
      end
      red  = take | eretT;
      expV = {take, code, bdx, epc, eretT, red, tgt, red, ~pipe[2].live};
      gotV = {exc_take, exc_code, exc_bd, exc_epc, eret_take, pc_redirect, pc_target, flush, m_bubble};
      checks++;
      if (gotV !== expV) begin
        errors++;
        $display("FAIL random cycle %0d got %h want %h", cyc, gotV, expV);
      end
      if (red) begin
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        sq = 1;
      end else begin
        nt = '0;
        nt.live = 1; nt.pc = f_pc; nt.bd = f_bd;
        if (!sq && f_exc_get) begin nt.hasExc = 1; nt.code = f_exc_code; end
        pipe[2] = pipe[1];
        if (stall) begin
          pipe[1] = '0;
        end else begin
          pipe[1] = pipe[0];
          pipe[0] = nt;
        end
        sq = 0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    idleInputs();
    reset = 1;
    test_reset();
    test_f_adel();
    test_delay_slot();
    test_oldest_wins();
    test_int_bubble();
    test_eret();
    test_stall_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_pipe_ctrl.md
# exc_pipe_ctrl

Exception sequencer for the five-stage MIPS pipeline. It carries per-instruction exception state (valid, PC, delay-slot flag, ExcCode) alongside the D/E/M pipeline registers, merging each stage's checker output (F/D/E/M ExcGet/ExcCode pairs) with oldest-first priority. At the M stage it commits exceptions and interrupts to CP0 and redirects fetch to the handler. It also sequences `eret` and runs a one-cycle post-redirect flush state.

## Interface
- HANDLER_ADDR, 32'h0000_4180, exception/interrupt entry PC
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- stall  in  1  hazard stall: hold F/D, bubble into E
- f_pc  in  32  PC of instruction in F
- f_bd  in  1  F instruction is a branch delay slot
- f_exc_get, d_exc_get, e_exc_get, m_exc_get  in  1 each  stage checker fired
- f_exc_code, d_exc_code, e_exc_code, m_exc_code  in  5 each  stage checker code
- m_eret  in  1  instruction in M is `eret`
- int_req  in  1  CP0 interrupt request (already masked by IE/EXL/IM)
- epc_in  in  32  current CP0 EPC
- exc_take  out  1  CP0 write strobe for EPC/Cause/EXL
- exc_code  out  5  Cause.ExcCode value (0 for interrupt)
- exc_bd  out  1  Cause.BD value
- exc_epc  out  32  EPC value
- eret_take  out  1  clear EXL strobe
- pc_redirect  out  1  override next PC
- pc_target  out  32  redirect target
- flush  out  1  clear F/D, D/E, E/M pipeline registers
- m_bubble  out  1  M holds no valid instruction

## Operation
- Per-stage record {v, pc, bd, xv, xcode} for D, E, M; the F record is formed from the inputs.
- Merge rule at each stage: if the incoming record has xv=1, keep it unchanged; else xv = stage exc_get, xcode = stage exc_code. The oldest exception wins, so a later stage never overwrites an earlier one.
- Advance rules:
  - stall=0: F→D, D→E, E→M.
  - stall=1: D holds its record, E loads a bubble (v=0, xv=0), M loads from E.
  - flush=1: D, E and M all load bubbles.
- States: RUN and SQUASH.
- Commit in RUN, in priority order:
  1. int_req & M.v: take the interrupt with code 0.
  2. M.v & merged M.xv: take the exception with merged M xcode.
  3. M.v & m_eret: eret_take=1, redirect to epc_in.
- On a take in RUN:
  - exc_take=1, exc_bd=M.bd.
  - exc_epc = M.bd ? M.pc−4 : M.pc (32-bit wrap).
  - pc_redirect=1, pc_target=HANDLER_ADDR, flush=1.
  - Next state SQUASH.
- On eret in RUN: pc_redirect=1, pc_target=epc_in, flush=1. Next state SQUASH.
- In SQUASH:
  - All commit outputs are forced to 0.
  - int_req and every exc_get are ignored, and records load as bubbles.
  - Returns to RUN the next cycle unconditionally.
- An exception on an `eret` in M takes the exception; eret_take stays 0.
- Interrupt and exception in M together: the interrupt wins with code 0, and the exception is discarded.
- stall and a commit in the same cycle: flush dominates and all records become bubbles.
- A bubble in M (M.v=0) never commits, even with int_req=1. The interrupt waits for the next valid instruction.

## Timing
- Reset values (next edge with reset=1): all records zero, state RUN.
- Outputs during and after reset: all 0, pc_target=0, m_bubble=1.
- Commit outputs are combinational from the M record and inputs in the same cycle. The CP0 write and PC override take effect at the following edge.
- Latency: an F checker fire reaches commit 3 cycles later with no stalls, plus 1 cycle per stall held in D.
- SQUASH lasts exactly 1 cycle. The first handler fetch enters D on the edge that leaves SQUASH.
- reset asserted in any state: reset wins over flush and commit, and the next state is RUN.
- Two back-to-back takes cannot happen: the minimum spacing is 2 cycles, guaranteed by SQUASH.

## Structure
- Shared package (`exc_pkg`):
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12.
  - HANDLER_ADDR default.
  - Record typedef {v, pc[31:0], bd, xv, xcode[4:0]}.
- Sub-module `exc_stage_reg` holds one stage's record, with the merge, stall-hold, bubble and flush logic. Instantiate it three times (D, E, M).
- The top level holds the FSM and the commit logic.

## Test plan
- F AdEL at pc 0x3004, no stall → 3 cycles later exc_take=1, exc_code=4, exc_epc=0x3004, pc_target=0x4180, flush=1; SQUASH one cycle.
- Delay-slot instruction pc 0x3010 (bd=1) with E overflow → exc_code=12, exc_bd=1, exc_epc=0x300C.
- F AdEL on an instruction, plus a D RI on the same instruction one cycle later → committed code 4 (oldest wins).
- int_req=1 while M holds a bubble, then a valid instruction at 0x3020 arrives → take on the valid cycle only, exc_code=0, exc_epc=0x3020.
- m_eret with epc_in=0x3040 → eret_take=1, pc_target=0x3040, flush=1; int_req during the following SQUASH cycle produces no take.
- Exception in D with stall held for 2 cycles, then reset mid-stream → commit delayed by 2 cycles; reset clears all records and all outputs are 0 the next cycle.
